ram_arbiter: RTL

- Two-port arbiter and sequencer in front of the byte-addressed data RAM (32 bytes, little-endian, combinational read, write on posedge when writeRam=1).
- Shares the RAM between port 0 (core load/store unit) and port 1 (debug/loader).
- Uses a req/gnt handshake, round-robin arbitration and a registered response.
- Rejects out-of-range accesses and illegal ctrl codes before they reach the RAM.

---
 rtl/ram_pkg.sv | 39 +++
 rtl/ram_access_check.sv | 29 ++
 rtl/ram_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the data-RAM arbiter and its RAM clients.
package ram_pkg;

  localparam int unsigned RAM_DEPTH = 32;

  typedef enum logic [2:0] {
    CTRL_B  = 3'b000,
    CTRL_H  = 3'b001,
    CTRL_W  = 3'b010,
    CTRL_BU = 3'b100,
    CTRL_HU = 3'b101
  } ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ram_req_t;

  // Bytes touched by an access; 0 marks an undefined ctrl code.
  function automatic logic [2:0] accessSize(input logic [2:0] ctrl);
    logic [2:0] size;
    case (ctrl)
      CTRL_B, CTRL_BU: size = 3'd1;
      CTRL_H, CTRL_HU: size = 3'd2;
      CTRL_W:          size = 3'd4;
      default:         size = 3'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/ram_access_check.sv
// Combinational legality check for a byte-addressed RAM access.
module ram_access_check
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH = RAM_DEPTH
) (
  input  logic [2:0]  ctrl,
  input  logic        we,
  input  logic [31:0] addr,
  output logic        legal
);

  logic [2:0]  size;
  logic [32:0] last_byte;
  logic        ctrl_ok;
  logic        store_ok;
  logic        range_ok;

  always_comb begin
    size      = accessSize(ctrl);
    ctrl_ok   = (size != '0);
    store_ok  = !(we && ctrl[2]);
    // 33-bit sum so addresses near 0xFFFFFFFF cannot wrap into range
    last_byte = {1'b0, addr} + 33'(size) - 33'd1;
    range_ok  = (last_byte <= 33'(DEPTH - 1));
    legal     = ctrl_ok && store_ok && range_ok;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and IDLE/ACCESS/RESP sequencer in front of the data RAM.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH = RAM_DEPTH
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        p0Req,
  input  logic        p0We,
  input  logic [2:0]  p0Ctrl,
  input  logic [31:0] p0Addr,
  input  logic [31:0] p0WData,
  input  logic        p1Req,
  input  logic        p1We,
  input  logic [2:0]  p1Ctrl,
  input  logic [31:0] p1Addr,
  input  logic [31:0] p1WData,
  output logic        p0Gnt,
  output logic        p0RValid,
  output logic [31:0] p0RData,
  output logic        p0Err,
  output logic        p1Gnt,
  output logic        p1RValid,
  output logic [31:0] p1RData,
  output logic        p1Err,
  output logic        writeRam,
  output logic [2:0]  ctrl,
  output logic [31:0] address,
  output logic [31:0] wData,
  input  logic [31:0] rData
);

  arb_state_e  state;
  arb_state_e  state_next;
  logic        last_owner;
  logic        owner;
  ram_req_t    req_q;
  ram_req_t    p0_req;
  ram_req_t    p1_req;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        legal;
  logic        gnt0;
  logic        gnt1;

  ram_access_check #(
    .DEPTH(DEPTH)
  ) u_check (
    .ctrl (req_q.ctrl),
    .we   (req_q.we),
    .addr (req_q.addr),
    .legal(legal)
  );

  always_comb begin
    p0_req = '{we: p0We, ctrl: p0Ctrl, addr: p0Addr, wdata: p0WData};
    p1_req = '{we: p1We, ctrl: p1Ctrl, addr: p1Addr, wdata: p1WData};
  end

  // Grants only in IDLE; on a tie the port that did not win last time goes first.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (nReset) begin
          if (p0Req && p1Req) begin
            gnt0 = last_owner;
            gnt1 = !last_owner;
          end else begin
            gnt0 = p0Req;
            gnt1 = p1Req;
          end
        end
        if (gnt0 || gnt1) state_next = ST_ACCESS;
      end
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    p0Gnt    = gnt0;
    p1Gnt    = gnt1;
    p0RValid = 1'b0;
    p0RData  = '0;
    p0Err    = 1'b0;
    p1RValid = 1'b0;
    p1RData  = '0;
    p1Err    = 1'b0;
    writeRam = 1'b0;
    ctrl     = '0;
    address  = '0;
    wData    = '0;
    case (state)
      ST_ACCESS: begin
        address  = req_q.addr;
        ctrl     = req_q.ctrl;
        wData    = req_q.wdata;
        writeRam = req_q.we && legal;
      end
      ST_RESP: begin
        if (owner) begin
          p1RValid = 1'b1;
          p1RData  = resp_data;
          p1Err    = resp_err;
        end else begin
          p0RValid = 1'b1;
          p0RData  = resp_data;
          p0Err    = resp_err;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      req_q      <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (gnt0 || gnt1) begin
        req_q      <= gnt1 ? p1_req : p0_req;
        owner      <= gnt1;
        last_owner <= gnt1;
      end
      if (state == ST_ACCESS) begin
        resp_data <= (legal && !req_q.we) ? rData : '0;
        resp_err  <= !legal;
      end
    end
  end

endmodule
